tick_gen_unit: RTL

TICK_GEN_UNIT -- requirements
Module: tick_gen_unit

---
 rtl/tick_gen_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/tick_gen_unit.sv
// Multi-channel tick generator: internal, external or debounced-button events feed per-channel dividers.
// Source changes pass through a two-cycle drain that clears the dividers before the new source is applied.
//   state | meaning
//   IDLE  | source applied, dividers counting
//   DRAIN | source change in progress, ticks suppressed, counters cleared
module tick_gen_unit #(
  parameter int N_CH       = 2,
  parameter int DIV_W      = 20,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ext_in,
  input  logic                  button_in,
  input  logic [1:0]            src_sel,
  input  logic [N_CH*DIV_W-1:0] div_val,
  input  logic                  enable,
  output logic [N_CH-1:0]       tick,
  output logic [1:0]            src_active,
  output logic                  switch_busy
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               drain_q, drain_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         act_q, act_d;
  logic [1:0]         sel_eff;
  logic               switching;
  logic               loaded_q;

  logic               ext_s1, ext_s2, ext_s3;
  logic               btn_s1, btn_s2, deb_state;
  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_diff, deb_flip;
  logic               ext_evt, man_evt, src_evt, manual;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_s1    <= 1'b0;
      ext_s2    <= 1'b0;
      ext_s3    <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      deb_state <= 1'b0;
      deb_cnt   <= '0;
      loaded_q  <= 1'b0;
    end else begin
      ext_s1   <= ext_in;
      ext_s2   <= ext_s1;
      ext_s3   <= ext_s2;
      btn_s1   <= button_in;
      btn_s2   <= btn_s1;
      loaded_q <= 1'b1;
      if (deb_flip) begin
        deb_state <= btn_s2;
        deb_cnt   <= '0;
      end else if (deb_diff) begin
        deb_cnt <= deb_cnt + 1'b1;
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Manual event fires on the same edge the debounced state rises, saving a cycle of latency.
  assign deb_diff = (btn_s2 != deb_state);
  assign deb_flip = deb_diff && (deb_cnt == DEB_W'(DEB_CYCLES - 1));
  assign man_evt  = deb_flip && btn_s2;
  assign ext_evt  = ext_s2 && !ext_s3;

  assign sel_eff = (src_sel == 2'b11) ? 2'b00 : src_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      pend_q  <= 2'b00;
      act_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pend_d  = pend_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE: begin
        if (sel_eff != act_q) begin
          state_d = DRAIN;
          drain_d = 1'b0;
          pend_d  = sel_eff;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          act_d   = pend_q;
        end else begin
          drain_d = 1'b1;
        end
      end
    endcase
  end

  // The detection cycle already counts as switching so coincident events never tick.
  assign switching   = (state_q == DRAIN) || (sel_eff != act_q);
  assign switch_busy = (state_q == DRAIN);
  assign src_active  = act_q;

  always_comb begin
    src_evt = 1'b1;
    unique case (act_q)
      2'b01:   src_evt = ext_evt;
      2'b10:   src_evt = man_evt;
      default: src_evt = 1'b1;
    endcase
  end

  assign manual = (act_q == 2'b10);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, shadow_q, div_i, last_q;
    logic             tick_q;

    assign div_i   = div_val[i*DIV_W +: DIV_W];
    assign last_q  = (shadow_q == '0) ? '0 : shadow_q - 1'b1;
    assign tick[i] = tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        shadow_q <= '0;
        tick_q   <= 1'b0;
      end else if (!loaded_q || switching) begin
        cnt_q    <= '0;
        shadow_q <= div_i;
        tick_q   <= 1'b0;
      end else if (enable && src_evt) begin
        if (manual) begin
          cnt_q  <= '0;
          tick_q <= 1'b1;
        end else if (cnt_q == last_q) begin
          cnt_q    <= '0;
          shadow_q <= div_i;
          tick_q   <= 1'b1;
        end else begin
          cnt_q  <= cnt_q + 1'b1;
          tick_q <= 1'b0;
        end
      end else begin
        tick_q <= 1'b0;
      end
    end
  end

endmodule
